// File: rtl/input_block_if.sv
// ---------------------------------------------------------------------------
// input_block_if : bundle of channel-side bit lanes and symbol-side outputs
//                  for input_block.
//   in0, in1   : lane bits, sampled when validIn=1
//   validIn    : beat qualifier
//   out        : reassembled 4-bit symbol
//   mode       : 0 = data symbol, 1 = termination symbol (qualified by validOut)
//   validOut   : one-cycle pulse per symbol
//   frameDone  : one-cycle pulse with the last tail symbol
//   frameErr   : sticky starvation flag (only with INPUT_BLOCK_FRAME_ERR_EN)
// Modports: master = channel/consumer side, slave = input_block.
// ---------------------------------------------------------------------------
interface input_block_if;
    logic       in0;
    logic       in1;
    logic       validIn;
    logic [3:0] out;
    logic       mode;
    logic       validOut;
    logic       frameDone;
`ifdef INPUT_BLOCK_FRAME_ERR_EN
    logic       frameErr;

    modport master (output in0, in1, validIn,
                    input  out, mode, validOut, frameDone, frameErr);
    modport slave  (input  in0, in1, validIn,
                    output out, mode, validOut, frameDone, frameErr);
`else
    modport master (output in0, in1, validIn,
                    input  out, mode, validOut, frameDone);
    modport slave  (input  in0, in1, validIn,
                    output out, mode, validOut, frameDone);
`endif
endinterface

// File: rtl/input_block.sv
// ---------------------------------------------------------------------------
// input_block : reassembles 4-bit symbols from two serial bit lanes and
//               tracks frame position (FRAME_LEN data + TAIL_LEN tail symbols).
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous active-low reset
//   bus    : input_block_if.slave (in0/in1/validIn in; out/mode/validOut/
//            frameDone out, plus frameErr when enabled)
// Optional feature macro: INPUT_BLOCK_FRAME_ERR_EN (starvation watchdog,
//   adds sticky frameErr).
// ---------------------------------------------------------------------------
module input_block #(
    parameter int FRAME_LEN = 4096,
    parameter int TAIL_LEN  = 3,
    parameter int CNT_W     = 13
) (
    input  logic          clk,
    input  logic          reset,
    input_block_if.slave  bus
);

    typedef enum logic {DATA, TAIL} state_t;

    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] TAIL_LAST = CNT_W'(TAIL_LEN - 1);

    state_t           state;
    logic             phase;      // 0: next beat is the low pair, 1: high pair
    logic [1:0]       lo;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       out_q;
    logic             mode_q;
    logic             valid_q;
    logic             done_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= DATA;
            phase   <= 1'b0;
            lo      <= '0;
            cnt     <= '0;
            out_q   <= '0;
            mode_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            if (bus.validIn) begin
                if (!phase) begin
                    lo    <= {bus.in1, bus.in0};
                    phase <= 1'b1;
                end else begin
                    phase   <= 1'b0;
                    out_q   <= {bus.in1, bus.in0, lo};
                    valid_q <= 1'b1;
                    case (state)
                        DATA: begin
                            mode_q <= 1'b0;
                            if (cnt == DATA_LAST) begin
                                cnt   <= '0;
                                state <= TAIL;
                            end else begin
                                cnt <= cnt + CNT_W'(1);
                            end
                        end
                        TAIL: begin
                            mode_q <= 1'b1;
                            if (cnt == TAIL_LAST) begin
                                cnt    <= '0;
                                state  <= DATA;
                                done_q <= 1'b1;
                            end else begin
                                cnt <= cnt + CNT_W'(1);
                            end
                        end
                        default: begin
                            state <= DATA;
                        end
                    endcase
                end
            end
        end
    end

    assign bus.out       = out_q;
    assign bus.mode      = mode_q;
    assign bus.validOut  = valid_q;
    assign bus.frameDone = done_q;

`ifdef INPUT_BLOCK_FRAME_ERR_EN
    localparam int             GAP_W     = CNT_W + 2;
    localparam logic [GAP_W-1:0] GAP_LIMIT = GAP_W'(2 * FRAME_LEN + 2 * TAIL_LEN);

    logic [GAP_W-1:0] gap_cnt;
    logic             frame_err;

    // The frame is judged on the edge after frameDone; a gap on that same
    // edge already belongs to the next frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gap_cnt   <= '0;
            frame_err <= 1'b0;
        end else if (done_q) begin
            if (gap_cnt > GAP_LIMIT) begin
                frame_err <= 1'b1;
            end
            gap_cnt <= bus.validIn ? '0 : GAP_W'(1);
        end else if (!bus.validIn && (gap_cnt != '1)) begin
            gap_cnt <= gap_cnt + GAP_W'(1);
        end
    end

    assign bus.frameErr = frame_err;
`endif

endmodule

// File: tb/tb_input_block.sv
// ---------------------------------------------------------------------------
// tb_input_block : directed bench for input_block. DUT 0 runs with a short
// frame (FRAME_LEN=4, TAIL_LEN=3), DUT 1 with default parameters. A frame-
// position model per DUT is checked against the outputs every cycle, and
// directed sequences pin hand-computed values.
// ---------------------------------------------------------------------------
module tb_input_block;

    logic clk;
    logic rst_n;

    int n_tests;
    int n_fail;
    logic check_en;

    logic       in0_s [2];
    logic       in1_s [2];
    logic       vin_s [2];
    logic [3:0] out_s [2];
    logic       mode_s [2];
    logic       vout_s [2];
    logic       done_s [2];
    logic       err_s [2];

    input_block_if if0 ();
    input_block_if if1 ();

    input_block #(.FRAME_LEN(4), .TAIL_LEN(3), .CNT_W(3)) dut0 (
        .clk   (clk),
        .reset (rst_n),
        .bus   (if0)
    );

    input_block dut1 (
        .clk   (clk),
        .reset (rst_n),
        .bus   (if1)
    );

    assign if0.in0 = in0_s[0];
    assign if0.in1 = in1_s[0];
    assign if0.validIn = vin_s[0];
    assign if1.in0 = in0_s[1];
    assign if1.in1 = in1_s[1];
    assign if1.validIn = vin_s[1];
    assign out_s[0]  = if0.out;
    assign out_s[1]  = if1.out;
    assign mode_s[0] = if0.mode;
    assign mode_s[1] = if1.mode;
    assign vout_s[0] = if0.validOut;
    assign vout_s[1] = if1.validOut;
    assign done_s[0] = if0.frameDone;
    assign done_s[1] = if1.frameDone;
`ifdef INPUT_BLOCK_FRAME_ERR_EN
    assign err_s[0] = if0.frameErr;
    assign err_s[1] = if1.frameErr;
`else
    assign err_s[0] = 1'b0;
    assign err_s[1] = 1'b0;
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int flen(input int d);
        return (d == 0) ? 4 : 4096;
    endfunction

    localparam int TLEN = 3;

    // ---------------- behavioural model ----------------
    // Frame position is one index 0..FRAME_LEN+TAIL_LEN-1; mode and frameDone
    // follow directly from where the index sits.
    logic       m_half [2];
    logic [1:0] m_lo [2];
    int         m_idx [2];
    logic [3:0] exp_out [2];
    logic       exp_v [2];
    logic       exp_m [2];
    logic       exp_d [2];
    int         m_gaps [2];
    logic       exp_err [2];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                m_half[d]  <= 1'b0;
                m_lo[d]    <= 2'b00;
                m_idx[d]   <= 0;
                exp_out[d] <= 4'h0;
                exp_v[d]   <= 1'b0;
                exp_m[d]   <= 1'b0;
                exp_d[d]   <= 1'b0;
                m_gaps[d]  <= 0;
                exp_err[d] <= 1'b0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                exp_v[d] <= 1'b0;
                exp_d[d] <= 1'b0;
                if (vin_s[d]) begin
                    if (!m_half[d]) begin
                        m_lo[d]   <= {in1_s[d], in0_s[d]};
                        m_half[d] <= 1'b1;
                    end else begin
                        m_half[d]  <= 1'b0;
                        exp_out[d] <= {in1_s[d], in0_s[d], m_lo[d]};
                        exp_v[d]   <= 1'b1;
                        exp_m[d]   <= (m_idx[d] >= flen(d));
                        exp_d[d]   <= (m_idx[d] == flen(d) + TLEN - 1);
                        m_idx[d]   <= (m_idx[d] + 1) % (flen(d) + TLEN);
                    end
                end
`ifdef INPUT_BLOCK_FRAME_ERR_EN
                if (exp_d[d]) begin
                    if (m_gaps[d] > 2 * flen(d) + 2 * TLEN) exp_err[d] <= 1'b1;
                    m_gaps[d] <= vin_s[d] ? 0 : 1;
                end else if (!vin_s[d]) begin
                    m_gaps[d] <= m_gaps[d] + 1;
                end
`endif
            end
        end
    end

    task automatic chk(input string name, input int d, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s dut%0d t=%0t: got %0d expected %0d", name, d, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            for (int d = 0; d < 2; d++) begin
                chk("model_validOut", d, int'(vout_s[d]), int'(exp_v[d]));
                chk("model_frameDone", d, int'(done_s[d]), int'(exp_d[d]));
                if (exp_v[d]) begin
                    chk("model_out", d, int'(out_s[d]), int'(exp_out[d]));
                    chk("model_mode", d, int'(mode_s[d]), int'(exp_m[d]));
                end
`ifdef INPUT_BLOCK_FRAME_ERR_EN
                chk("model_frameErr", d, int'(err_s[d]), int'(exp_err[d]));
`endif
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input int d, input logic v, input logic b1, input logic b0);
        vin_s[d] = v;
        in1_s[d] = b1;
        in0_s[d] = b0;
        @(posedge clk);
        #1;
    endtask

    task automatic send_sym(input int d, input logic [3:0] s);
        drive(d, 1'b1, s[1], s[0]);
        drive(d, 1'b1, s[3], s[2]);
    endtask

    task automatic idle(input int d);
        drive(d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        for (int d = 0; d < 2; d++) begin
            vin_s[d] = 1'b0;
            in0_s[d] = 1'b0;
            in1_s[d] = 1'b0;
        end
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_data;
        int n_tail;
        int n_done;
        int done_at;
        logic last_mode;
        n_tests  = 0;
        n_fail   = 0;
        check_en = 1'b0;
        rst_n    = 1'b1;
        for (int d = 0; d < 2; d++) begin
            vin_s[d] = 1'b0;
            in0_s[d] = 1'b0;
            in1_s[d] = 1'b0;
        end
        #1;
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("reset_out", d, int'(out_s[d]), 0);
            chk("reset_mode", d, int'(mode_s[d]), 0);
            chk("reset_validOut", d, int'(vout_s[d]), 0);
            chk("reset_frameDone", d, int'(done_s[d]), 0);
            chk("reset_frameErr", d, int'(err_s[d]), 0);
        end
        do_reset();
        check_en = 1'b1;

        // First symbol: pairs (0,1) then (1,0) -> 4'b1001
        send_sym(0, 4'b1001);
        chk("t1_out", 0, int'(out_s[0]), 9);
        chk("t1_mode", 0, int'(mode_s[0]), 0);
        chk("t1_valid", 0, int'(vout_s[0]), 1);
        idle(0);
        chk("t1_valid_pulse", 0, int'(vout_s[0]), 0);
        chk("t1_out_hold", 0, int'(out_s[0]), 9);

        // Short frame: symbols 1..7, tail = 5,6,7
        do_reset();
        for (int s = 1; s <= 7; s++) begin
            send_sym(0, 4'(s));
            chk("t2_out", 0, int'(out_s[0]), s);
            chk("t2_mode", 0, int'(mode_s[0]), (s >= 5) ? 1 : 0);
            chk("t2_done", 0, int'(done_s[0]), (s == 7) ? 1 : 0);
        end
        idle(0);
        chk("t2_done_pulse", 0, int'(done_s[0]), 0);

        // Half symbol held across a 5-cycle gap
        drive(0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            idle(0);
            chk("t3_gap_valid", 0, int'(vout_s[0]), 0);
        end
        drive(0, 1'b1, 1'b0, 1'b0);
        chk("t3_out", 0, int'(out_s[0]), 3);
        chk("t3_valid", 0, int'(vout_s[0]), 1);
        chk("t3_mode", 0, int'(mode_s[0]), 0);
        idle(0);

        // Reset after beat 0 of data symbol 2
        do_reset();
        send_sym(0, 4'hA);
        send_sym(0, 4'h6);
        drive(0, 1'b1, 1'b1, 1'b1);
        vin_s[0] = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_out", 0, int'(out_s[0]), 0);
        chk("t5_rst_valid", 0, int'(vout_s[0]), 0);
        chk("t5_rst_mode", 0, int'(mode_s[0]), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send_sym(0, 4'b0101);
        chk("t5_out", 0, int'(out_s[0]), 5);
        chk("t5_mode", 0, int'(mode_s[0]), 0);
        for (int i = 0; i < 3; i++) begin
            send_sym(0, 4'hC);
            chk("t5_data_mode", 0, int'(mode_s[0]), 0);
        end
        send_sym(0, 4'h2);
        chk("t5_tail_mode", 0, int'(mode_s[0]), 1);
        idle(0);

        // Default parameters: one full frame plus first symbol of the next
        do_reset();
        n_data = 0;
        n_tail = 0;
        n_done = 0;
        done_at = -1;
        last_mode = 1'b1;
        for (int i = 0; i < 4096 + 3 + 1; i++) begin
            send_sym(1, 4'(i));
            if (vout_s[1]) begin
                if (mode_s[1]) n_tail++;
                else n_data++;
                if (done_s[1]) begin
                    n_done++;
                    done_at = i;
                end
                last_mode = mode_s[1];
            end
        end
        idle(1);
        chk("t4_data_count", 1, n_data, 4097);
        chk("t4_tail_count", 1, n_tail, 3);
        chk("t4_done_count", 1, n_done, 1);
        chk("t4_done_index", 1, done_at, 4098);
        chk("t4_next_frame_mode", 1, int'(last_mode), 0);

`ifdef INPUT_BLOCK_FRAME_ERR_EN
        // Gap-free frame: no error
        do_reset();
        for (int s = 1; s <= 7; s++) send_sym(0, 4'(s));
        chk("t6_done", 0, int'(done_s[0]), 1);
        idle(0);
        chk("t6_err_clean", 0, int'(err_s[0]), 0);
        idle(0);
        chk("t6_err_clean_hold", 0, int'(err_s[0]), 0);

        // Same frame with 20 gap cycles inside it
        do_reset();
        for (int s = 1; s <= 3; s++) send_sym(0, 4'(s));
        for (int i = 0; i < 20; i++) idle(0);
        for (int s = 4; s <= 7; s++) send_sym(0, 4'(s));
        chk("t6_gap_done", 0, int'(done_s[0]), 1);
        chk("t6_err_before", 0, int'(err_s[0]), 0);
        idle(0);
        chk("t6_err_set", 0, int'(err_s[0]), 1);
        for (int i = 0; i < 3; i++) idle(0);
        chk("t6_err_sticky", 0, int'(err_s[0]), 1);
`endif

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
